// File: rtl/sc_preamble_inserter_pkg.sv
// Shared types and the Schmidl-Cox half-symbol generator for sc_preamble_inserter.
// The half-symbol is QPSK mapped from a 7-bit x^7+x^6+1 PN sequence.
package sc_pkg;

  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
  } sample_t;

  typedef enum logic [1:0] {
    IDLE,
    PRE_CP,
    PRE_BODY,
    PAYLOAD
  } sc_state_t;

  localparam logic [6:0] PN_SEED = 7'h7F;
  localparam logic [6:0] PN_TAPS = 7'b110_0000;  // x^7 + x^6

  // Sample idx uses PN output bits 2*idx (I) and 2*idx+1 (Q); a set bit maps to -amp.
  function automatic sample_t sc_half_sample(input int idx, input logic signed [15:0] amp);
    logic [6:0] lfsr;
    logic       b_i;
    logic       b_q;
    sample_t    s;
    lfsr = PN_SEED;
    b_i  = 1'b0;
    b_q  = 1'b0;
    for (int n = 0; n <= 2 * idx + 1; n++) begin
      if (n == 2 * idx)     b_i = lfsr[6];
      if (n == 2 * idx + 1) b_q = lfsr[6];
      lfsr = {lfsr[5:0], ^(lfsr & PN_TAPS)};
    end
    s.i = b_i ? -amp : amp;
    s.q = b_q ? -amp : amp;
    return s;
  endfunction

endpackage

// File: rtl/sc_preamble_inserter_if.sv
// Payload-in / frame-out stream bundle of sc_preamble_inserter.
// The slave modport is the inserter's view; master is the surrounding logic's view.
interface sc_preamble_inserter_if;
  import sc_pkg::*;

  sample_t i_tdata;
  logic    i_tlast;
  logic    i_tvalid;
  logic    i_tready;
  sample_t o_tdata;
  logic    o_tlast;
  logic    o_tvalid;
  logic    o_tready;
  logic    o_in_preamble;

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tlast, o_tvalid, o_in_preamble
  );

  modport master (
    output i_tdata, i_tlast, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tlast, o_tvalid, o_in_preamble
  );
endinterface

// File: rtl/sc_preamble_inserter_rom.sv
// Registered half-symbol lookup: idx -> PN-mapped preamble sample, one cycle latency.
module sc_preamble_rom
  import sc_pkg::*;
#(
  parameter int HALF = 32,
  parameter int AMP  = 5793,
  localparam int IDX_W = $clog2(HALF)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [IDX_W-1:0] idx,
  output sample_t          data
);

  localparam logic signed [15:0] AMP16 = 16'(AMP);

  sample_t rom_tab [HALF];

  for (genvar g = 0; g < HALF; g++) begin : g_tab
    assign rom_tab[g] = sc_half_sample(g, AMP16);
  end

  // NOTE: the table is constant logic with nothing to reset; only the output register is reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   data <= '0;
    else if (clear) data <= '0;
    else            data <= rom_tab[idx];
  end

endmodule

// File: rtl/sc_preamble_inserter.sv
// Prepends a Schmidl-Cox training symbol (optional CP + two identical PN halves) to each packet.
// Define SC_PREAMBLE_CP_EN to emit the CP_LEN-sample cyclic prefix ahead of the two halves.
module sc_preamble_inserter
  import sc_pkg::*;
#(
  parameter int FFT_SIZE = 64,
  parameter int CP_LEN   = 16,
  parameter int AMP      = 5793
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  sc_preamble_inserter_if.slave bus
);

  localparam int HALF  = FFT_SIZE / 2;
  localparam int CNT_W = $clog2(FFT_SIZE);
  localparam int IDX_W = $clog2(HALF);

  if (FFT_SIZE < 4 || (FFT_SIZE & (FFT_SIZE - 1)) != 0) begin : g_bad_fft
    $error("sc_preamble_inserter: FFT_SIZE must be a power of two >= 4");
  end
  if (CP_LEN <= 0 || CP_LEN > HALF) begin : g_bad_cp
    $error("sc_preamble_inserter: CP_LEN must be in 1..FFT_SIZE/2");
  end

`ifdef SC_PREAMBLE_CP_EN
  localparam sc_state_t FIRST_PRE = PRE_CP;
`else
  localparam sc_state_t FIRST_PRE = PRE_BODY;
`endif

  sc_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [IDX_W-1:0] idx_next;
  sample_t          rom_q;
  logic             hs;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (clear) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Output mux: preamble from the registered ROM, payload passed straight through.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    bus.o_tvalid      = 1'b0;
    bus.o_tdata       = '0;
    bus.o_tlast       = 1'b0;
    bus.o_in_preamble = 1'b0;
    bus.i_tready      = 1'b0;
    case (state)
      PRE_CP, PRE_BODY: begin
        bus.o_tvalid      = 1'b1;
        bus.o_tdata       = rom_q;
        bus.o_in_preamble = 1'b1;
      end
      PAYLOAD: begin
        bus.o_tvalid = bus.i_tvalid;
        bus.o_tdata  = bus.i_tdata;
        bus.o_tlast  = bus.i_tlast;
        bus.i_tready = bus.o_tready;
      end
      default: ;
    endcase
  end

  assign hs = bus.o_tvalid && bus.o_tready;

  // The ROM is addressed with the next beat's index so its registered output lines up with
  // the state; a stalled beat keeps the same index and therefore the same data.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (bus.i_tvalid) state_next = FIRST_PRE;
`ifdef SC_PREAMBLE_CP_EN
      PRE_CP:   if (hs && cnt == CNT_W'(CP_LEN - 1)) state_next = PRE_BODY;
`endif
      PRE_BODY: if (hs && cnt == CNT_W'(FFT_SIZE - 1)) state_next = PAYLOAD;
      PAYLOAD:  if (hs && bus.i_tlast) state_next = IDLE;
      default:  state_next = IDLE;
    endcase

    if (state_next != state) cnt_next = '0;
    else if (hs)             cnt_next = cnt + CNT_W'(1);
    else                     cnt_next = cnt;

    idx_next = '0;
    if (state_next == PRE_BODY) idx_next = cnt_next[IDX_W-1:0];
`ifdef SC_PREAMBLE_CP_EN
    else if (state_next == PRE_CP) idx_next = IDX_W'(HALF - CP_LEN + int'(cnt_next));
`endif
  end

  sc_preamble_rom #(
    .HALF (HALF),
    .AMP  (AMP)
  ) u_rom (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .idx     (idx_next),
    .data    (rom_q)
  );

endmodule

// File: tb/tb_sc_preamble_inserter.sv
// Scoreboard bench for sc_preamble_inserter: expected frames are built from the PN recurrence
// and queued at packet start; a negedge monitor pops and compares every accepted output beat.
module tb_sc_preamble_inserter;
  import sc_pkg::*;

  localparam int FFT_SIZE = 8;
  localparam int CP_LEN   = 2;
  localparam int AMP      = 5793;
  localparam int HALF     = FFT_SIZE / 2;
`ifdef SC_PREAMBLE_CP_EN
  localparam int PRE_LEN = CP_LEN + FFT_SIZE;
`else
  localparam int PRE_LEN = FFT_SIZE;
`endif

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        pre;
    logic        gap_chk;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;

  exp_t        sb[$];
  logic [31:0] pkt[$];
  logic        pn[2*HALF+7];
  int          n_vec = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          beats_in_frame = 0;
  bit          rand_ready = 1'b0;
  bit          gaps_on = 1'b0;

  sc_preamble_inserter_if bus ();

  sc_preamble_inserter #(
    .FFT_SIZE (FFT_SIZE),
    .CP_LEN   (CP_LEN),
    .AMP      (AMP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: PN bit sequence s[t+7] = s[t] ^ s[t+1] from an all-ones start.
  function automatic void build_pn();
    for (int t = 0; t < 2 * HALF + 7; t++) pn[t] = (t < 7) ? 1'b1 : (pn[t-7] ^ pn[t-6]);
  endfunction

  function automatic int half_index(input int k);
`ifdef SC_PREAMBLE_CP_EN
    if (k < CP_LEN) return HALF - CP_LEN + k;
    return (k - CP_LEN) % HALF;
`else
    return k % HALF;
`endif
  endfunction

  function automatic logic [31:0] pre_sample(input int h);
    logic [15:0] iv;
    logic [15:0] qv;
    iv = pn[2*h]   ? 16'(-AMP) : 16'(AMP);
    qv = pn[2*h+1] ? 16'(-AMP) : 16'(AMP);
    return {iv, qv};
  endfunction

  task automatic push_frame(input bit gap_chk);
    for (int k = 0; k < PRE_LEN; k++)
      sb.push_back(exp_t'{pre_sample(half_index(k)), 1'b0, 1'b1, gap_chk && k == 0});
    for (int i = 0; i < pkt.size(); i++)
      sb.push_back(exp_t'{pkt[i], i == pkt.size() - 1, 1'b0, 1'b0});
  endtask

  // Abort the frame in flight once `at` beats have gone out, by reset or by clear.
  task automatic do_abort(input int at, input bit use_clear);
    int t = 0;
    while (beats_in_frame != at && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    check("abort_point", 64'(beats_in_frame), 64'(at));
    if (use_clear) begin
      clear = 1'b1;
      @(posedge clk); #1;
    end else begin
      reset_n = 1'b0;
      #1;
    end
    check("abort_o_tvalid", bus.o_tvalid, 0);
    check("abort_o_tdata", bus.o_tdata, 0);
    check("abort_o_tlast", bus.o_tlast, 0);
    check("abort_o_in_pre", bus.o_in_preamble, 0);
    check("abort_i_tready", bus.i_tready, 0);
    sb.delete();
    if (use_clear) clear = 1'b0;
    else begin
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
    end
    push_frame(1'b0);
  endtask

  task automatic send_packet(input int abort_at, input bit use_clear, input bit gap_chk);
    int t;
    push_frame(gap_chk);
    for (int i = 0; i < pkt.size(); i++) begin
      if (gaps_on) begin
        bus.i_tvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      bus.i_tdata  = pkt[i];
      bus.i_tlast  = (i == pkt.size() - 1);
      bus.i_tvalid = 1'b1;
      if (i == 0 && abort_at > 0) do_abort(abort_at, use_clear);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!bus.i_tready && t < 5000);
      if (!bus.i_tready) begin
        n_vec++;
        n_fail++;
        $display("FAIL handshake_timeout: beat %0d never accepted", i);
        bus.i_tvalid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    bus.i_tvalid = 1'b0;
    bus.i_tlast  = 1'b0;
  endtask

  initial begin : ready_driver
    bus.o_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.o_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : monitor
    exp_t        e;
    logic        stalled = 1'b0;
    logic [33:0] held = '0;
    int          last_cyc = -100;
    int          mag_i;
    int          mag_q;
    forever begin
      @(negedge clk);
      if (!reset_n || clear) begin
        stalled = 1'b0;
        beats_in_frame = 0;
        continue;
      end
      if (stalled) begin
        check("stall_valid", bus.o_tvalid, 1);
        check("stall_hold", {bus.o_tdata, bus.o_tlast, bus.o_in_preamble}, held);
      end
      stalled = bus.o_tvalid && !bus.o_tready;
      held = {bus.o_tdata, bus.o_tlast, bus.o_in_preamble};
      if (bus.o_tvalid && bus.o_tready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h with no beat expected", bus.o_tdata);
        end else begin
          e = sb.pop_front();
          check("tdata", bus.o_tdata, e.data);
          check("tlast", bus.o_tlast, e.last);
          check("in_preamble", bus.o_in_preamble, e.pre);
          if (e.pre) begin
            mag_i = (bus.o_tdata.i < 0) ? -int'(bus.o_tdata.i) : int'(bus.o_tdata.i);
            mag_q = (bus.o_tdata.q < 0) ? -int'(bus.o_tdata.q) : int'(bus.o_tdata.q);
            check("amp_i", 64'(mag_i), 64'(AMP));
            check("amp_q", 64'(mag_q), 64'(AMP));
          end
          if (e.gap_chk) check("idle_gap", 64'(cyc - last_cyc), 64'(2));
          if (bus.o_tlast) last_cyc = cyc;
          beats_in_frame = bus.o_tlast ? 0 : beats_in_frame + 1;
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int t;
    build_pn();
    bus.i_tdata  = '0;
    bus.i_tlast  = 1'b0;
    bus.i_tvalid = 1'b0;
    #1;
    check("rst_o_tvalid", bus.o_tvalid, 0);
    check("rst_o_tdata", bus.o_tdata, 0);
    check("rst_o_tlast", bus.o_tlast, 0);
    check("rst_o_in_pre", bus.o_in_preamble, 0);
    check("rst_i_tready", bus.i_tready, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_o_tvalid", bus.o_tvalid, 0);
    end
    @(posedge clk); #1;

    // Reference packet, full-rate sink.
    pkt = '{32'h0001_0002, 32'h0003_0004, 32'h0005_0006, 32'h0007_0008};
    send_packet(0, 1'b0, 1'b0);

    // Same packet with sink stalls and source gaps.
    rand_ready = 1'b1;
    gaps_on    = 1'b1;
    send_packet(0, 1'b0, 1'b0);
    rand_ready = 1'b0;
    gaps_on    = 1'b0;

    // Back-to-back single-sample packets: exactly one IDLE cycle between frames.
    pkt = '{32'hA5A5_0001};
    send_packet(0, 1'b0, 1'b0);
    pkt = '{32'h5A5A_0002};
    send_packet(0, 1'b0, 1'b1);

    // Asynchronous reset at preamble beat 5, then synchronous clear at beat 3.
    pkt = '{32'h1111_2222, 32'h3333_4444};
    send_packet(5, 1'b0, 1'b0);
    pkt = '{32'h5555_6666, 32'h7777_8888, 32'h9999_AAAA};
    send_packet(3, 1'b1, 1'b0);

    // Random packets under random backpressure.
    rand_ready = 1'b1;
    gaps_on    = 1'b1;
    for (int p = 0; p < 6; p++) begin
      pkt.delete();
      repeat ($urandom_range(1, 6)) pkt.push_back($urandom);
      send_packet(0, 1'b0, 1'b0);
    end
    rand_ready = 1'b0;

    t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check("scoreboard_drained", 64'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_preamble_inserter.md
# sc_preamble_inserter

Transmit-side counterpart of the Schmidl-Cox timing synchroniser. Prepends a Schmidl-Cox training symbol to every tlast-delimited payload packet: a half-symbol of FFT_SIZE/2 fixed PN samples, emitted twice, preceded by an optional cyclic prefix. It sits on the OFDM TX path ahead of the radio, so the RX metric calculator sees the repeated-half correlation peak at the start of each frame.

## Interface
- FFT_SIZE, 64, OFDM symbol length in samples; power of two, ≥4
- CP_LEN, 16, preamble cyclic-prefix length; 0 < CP_LEN ≤ FFT_SIZE/2, elaboration $error otherwise
- AMP, 5793, magnitude of each preamble I/Q component (signed 16-bit)
- Reset: one clock; reset is asynchronous and active-low
- clk  in  1  sample clock
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear, same effect as reset
- i_tdata  in  32  payload sample, I=[31:16], Q=[15:0]
- i_tlast  in  1  last payload sample of packet
- i_tvalid  in  1  payload valid
- i_tready  out  1  payload ready
- o_tdata  out  32  output sample, same I/Q packing
- o_tlast  out  1  last sample of frame (= payload i_tlast)
- o_tvalid  out  1  output valid
- o_tready  in  1  output ready
- o_in_preamble  out  1  high while current o_tdata is a preamble sample

## Operation
- States: IDLE, PRE_CP, PRE_BODY, PAYLOAD.
- IDLE: i_tready=0, o_tvalid=0. i_tvalid=1 → PRE_CP (PRE_BODY when CP disabled); payload sample is not consumed.
- PRE_CP: emits CP_LEN samples, k=0..CP_LEN-1 → half-index FFT_SIZE/2-CP_LEN+k. After last CP beat → PRE_BODY.
- PRE_BODY: emits FFT_SIZE samples, j=0..FFT_SIZE-1 → half-index j mod FFT_SIZE/2. After last beat → PAYLOAD.
- Half-symbol sample n: I = PN bit 2n ? −AMP : +AMP, Q = PN bit 2n+1 ? −AMP : +AMP; PN = 7-bit LFSR x^7+x^6+1, seed 7'h7F, first output bit used first.
- Preamble beats: o_tvalid=1, o_tlast=0, o_in_preamble=1, i_tready=0.
- PAYLOAD: combinational pass-through: o_tdata=i_tdata, o_tlast=i_tlast, o_tvalid=i_tvalid, i_tready=o_tready, o_in_preamble=0. Beat with i_tlast accepted → IDLE.
- Single sample counter, width $clog2(FFT_SIZE), advances only on o_tvalid&&o_tready; zeroed on every state change.
- clear/reset mid-frame: preamble or payload aborted, state IDLE; remaining upstream samples of the aborted packet are treated as a new packet and receive a fresh preamble.

## Timing
- Reset values: o_tdata=0, o_tlast=0, o_tvalid=0, i_tready=0, o_in_preamble=0, state IDLE, counter 0.
- Preamble samples registered: first preamble beat valid the cycle after i_tvalid seen in IDLE.
- Preamble duration with o_tready=1: CP_LEN+FFT_SIZE cycles; payload latency 0 cycles once in PAYLOAD.
- AXI-Stream rules: o_tdata/o_tlast/o_in_preamble stable while o_tvalid && !o_tready; o_tvalid never drops without a handshake.
- i_tvalid deasserting during preamble has no effect; preamble completes.
- Back-to-back packets: tlast beat and next packet's i_tvalid → one IDLE cycle, then new preamble.

## Configuration
- SC_PREAMBLE_CP_EN defined: PRE_CP present, preamble length CP_LEN+FFT_SIZE.
- Undefined: PRE_CP removed, IDLE → PRE_BODY directly, preamble length FFT_SIZE, CP_LEN ignored.

## Structure
- Package sc_pkg: sample_t (packed I/Q 16+16), sc_state_t enum, LFSR polynomial/seed constants, function sc_half_sample(idx, amp).
- Sub-module sc_preamble_rom: registered lookup, idx → 32-bit half-symbol sample, table built at elaboration from sc_half_sample.

## Test plan
- FFT_SIZE=8, CP_LEN=2, CP on, o_tready=1, 4-sample packet 0x00010002..0x00070008 → 10 preamble beats (half-indices 2,3,0,1,2,3,0,1,2,3), then 4 payload beats identical, o_tlast on 14th beat only.
- Same, random o_tready/i_tvalid gaps → identical output sequence; no data change while stalled.
- Two back-to-back packets of 1 sample → each preceded by full 10-beat preamble, one IDLE cycle between.
- reset_n low at preamble beat 5 → all outputs 0 immediately; after release, new packet gets full preamble from beat 0.
- SC_PREAMBLE_CP_EN undefined → 8 preamble beats, first = half-index 0; second half equals first half bit-exact.
- Check AMP=5793: every preamble I/Q ∈ {+5793, −5793}; o_in_preamble high exactly on preamble beats.
